// File: rtl/mips_fetch_unit_pkg.sv
// mips_fetch_unit_pkg: shared fetch-stage state encodings and instruction-field constants
// Imported by mips_fetch_unit and mips_fetch_unit_pc_next.
// Contents:
//   fetchState_t           S_REQ (fetching), S_HOLD (IR live), S_ERR (memory timeout)
//   INSTR_W                instruction word width
//   OPCODE_MSB/OPCODE_LSB  opcode field position inside the instruction word
//   BRANCH_OFF_W           width of the raw branch immediate
package mips_fetch_unit_pkg;
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } fetchState_t;
    localparam int INSTR_W      = 32;
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int BRANCH_OFF_W = 16;
endpackage

// File: rtl/mips_fetch_unit_pc_next.sv
// mips_fetch_unit_pc_next: combinational next-PC computation for the fetch stage
// Ports:
//   pc            in   AW  address of the instruction being consumed
//   branchTaken   in   1   select branch target instead of sequential PC
//   branchOffset  in   16  raw branch immediate (word offset, signed)
//   pcNext        out  AW  pc+4, or pc+4+(sext(branchOffset)<<2) when branchTaken
//   pcPlus4       out  AW  pc+4
// All arithmetic wraps modulo 2^AW.
module mips_fetch_unit_pc_next
    import mips_fetch_unit_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0]           pc,
    input  logic                    branchTaken,
    input  logic [BRANCH_OFF_W-1:0] branchOffset,
    output logic [AW-1:0]           pcNext,
    output logic [AW-1:0]           pcPlus4
);
    logic [AW-1:0] branchDisp;

    assign branchDisp = {{(AW-BRANCH_OFF_W-2){branchOffset[BRANCH_OFF_W-1]}}, branchOffset, 2'b00};
    assign pcPlus4    = pc + AW'(4);
    assign pcNext     = branchTaken ? pcPlus4 + branchDisp : pcPlus4;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS instruction fetch stage with req/ack instruction memory and IR
// Optional feature: define FETCH_TIMEOUT_EN to abort to S_ERR after TIMEOUT_CYCLES
// consecutive unacknowledged request cycles (fetch_err then sticks until Reset).
// Ports:
//   CLK, Reset            clock; synchronous active-high reset
//   imem_req/imem_addr    fetch request and word byte address (= PC)
//   imem_ack/imem_rdata   memory response, data valid with ack
//   stall                 downstream not ready, hold the current instruction
//   branch_taken/offset   branch decision, used only when the instruction is consumed
//   instr_valid           Instruction/Opcode/PC_out hold a live instruction
//   Instruction/Opcode    instruction register and its opcode field
//   PC_out/PC_plus4       address of the instruction in IR and that address + 4
//   fetch_err             sticky memory-timeout flag (constant 0 without FETCH_TIMEOUT_EN)
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter int            AW             = 32,
    parameter logic [AW-1:0] RESET_PC       = '0,
    parameter int            TIMEOUT_CYCLES = 16
) (
    input  logic                          CLK,
    input  logic                          Reset,
    output logic                          imem_req,
    output logic [AW-1:0]                 imem_addr,
    input  logic                          imem_ack,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [BRANCH_OFF_W-1:0]       branch_offset,
    output logic                          instr_valid,
    output logic [INSTR_W-1:0]            Instruction,
    output logic [OPCODE_MSB-OPCODE_LSB:0] Opcode,
    output logic [AW-1:0]                 PC_out,
    output logic [AW-1:0]                 PC_plus4,
    output logic                          fetch_err
);
    fetchState_t   state, stateNext;
    logic [AW-1:0] pc, pcNext;
    logic          timeoutHit;
    logic          accept, consume;

    assign accept    = (state == S_REQ) && imem_ack;
    assign consume   = (state == S_HOLD) && !stall;
    assign imem_req  = (state == S_REQ) && !Reset;
    assign imem_addr = pc;
    assign Opcode    = Instruction[OPCODE_MSB:OPCODE_LSB];

    // PC_out equals pc whenever a consume can happen (S_HOLD), so one adder chain
    // serves both the branch target and the PC_plus4 output.
    mips_fetch_unit_pc_next #(.AW(AW)) uPcNext (
        .pc           (PC_out),
        .branchTaken  (branch_taken),
        .branchOffset (branch_offset),
        .pcNext       (pcNext),
        .pcPlus4      (PC_plus4)
    );

    always_comb begin
        stateNext = state;
        stateNext = (state == S_REQ)  ? (imem_ack ? S_HOLD : timeoutHit ? S_ERR : S_REQ) :
                    (state == S_HOLD) ? (stall ? S_HOLD : S_REQ) : state;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_REQ;
            pc          <= {RESET_PC[AW-1:2], 2'b00};
            Instruction <= '0;
            PC_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                Instruction <= imem_rdata;
                PC_out      <= pc;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                pc          <= pcNext;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;
    logic             fetchErr;

    // Hit in the TIMEOUT_CYCLES-th consecutive request cycle; an ack in that cycle still wins.
    assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err  = fetchErr;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            waitCnt  <= '0;
            fetchErr <= 1'b0;
        end else if (state == S_REQ) begin
            waitCnt  <= imem_ack ? '0 : waitCnt + 1'b1;
            fetchErr <= fetchErr | (!imem_ack && timeoutHit);
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign fetch_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        instr_valid;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastIr = '0;

    mips_fetch_unit #(.AW(32), .RESET_PC(32'h100), .TIMEOUT_CYCLES(4)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr_valid   (instr_valid),
        .Instruction   (Instruction),
        .Opcode        (Opcode),
        .PC_out        (PC_out),
        .PC_plus4      (PC_plus4),
        .fetch_err     (fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(negedge CLK);
    endtask

    task automatic do_fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
        for (int i = 0; i < waits; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== addr) begin
                errors++;
                $display("FAIL wait_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, addr);
            end
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
            checks++;
            if (instr_valid !== 1'b0 || Instruction !== lastIr) begin
                errors++;
                $display("FAIL wait_ir: valid=%b ir=%h expected valid=0 ir=%h", instr_valid, Instruction, lastIr);
            end
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++;
            $display("FAIL ack_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        lastIr     = data;
        checks++;
        if (instr_valid !== 1'b1 || Instruction !== data || Opcode !== data[31:26]) begin
            errors++;
            $display("FAIL capture: valid=%b ir=%h op=%h expected valid=1 ir=%h op=%h",
                     instr_valid, Instruction, Opcode, data, data[31:26]);
        end
        checks++;
        if (PC_out !== addr || PC_plus4 !== addr + 32'd4 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_pc: pc_out=%h pc_plus4=%h req=%b expected %h %h 0",
                     PC_out, PC_plus4, imem_req, addr, addr + 32'd4);
        end
    endtask

    task automatic consume(input logic taken, input logic [15:0] off, input logic [31:0] nextAddr);
        stall         = 1'b0;
        branch_taken  = taken;
        branch_offset = off;
        step();
        stall         = 1'b1;
        branch_taken  = 1'b0;
        branch_offset = '0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== nextAddr) begin
            errors++;
            $display("FAIL next_fetch: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, nextAddr);
        end
        checks++;
        if (instr_valid !== 1'b0 || Instruction !== lastIr) begin
            errors++;
            $display("FAIL after_consume: valid=%b ir=%h expected valid=0 ir=%h", instr_valid, Instruction, lastIr);
        end
    endtask

    task automatic test_reset;
        Reset    = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        checks++;
        if (instr_valid !== 1'b0 || Instruction !== 32'h0 || PC_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b ir=%h pc_out=%h expected 0 0 0", instr_valid, Instruction, PC_out);
        end
        checks++;
        if (imem_req !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: req=%b err=%b expected 0 0", imem_req, fetch_err);
        end
        Reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_fetch: req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
        end
        lastIr = '0;
    endtask

    task automatic test_sequential;
        do_fetch(0, 32'h8C22_0004, 32'h100);
        consume(1'b0, 16'h0000, 32'h104);
        do_fetch(0, 32'h0043_2020, 32'h104);
        consume(1'b0, 16'h0000, 32'h108);
        do_fetch(0, 32'h1062_003D, 32'h108);
        consume(1'b1, 16'h003D, 32'h200);
    endtask

    task automatic test_wait_states;
        do_fetch(3, 32'hAC43_0008, 32'h200);
    endtask

    task automatic test_stall;
        for (int i = 0; i < 5; i++) begin
            stall         = 1'b1;
            branch_taken  = 1'b1;
            branch_offset = 16'h7FFF;
            imem_ack      = 1'b1;
            imem_rdata    = 32'hFFFF_FFFF;
            step();
            checks++;
            if (instr_valid !== 1'b1 || Instruction !== lastIr || PC_out !== 32'h200 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b ir=%h pc_out=%h req=%b expected 1 %h 00000200 0",
                         instr_valid, Instruction, PC_out, imem_req, lastIr);
            end
        end
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_branch;
        consume(1'b1, 16'hFFFE, 32'h1FC);
        do_fetch(0, 32'h1000_0000, 32'h1FC);
        consume(1'b1, 16'h0000, 32'h200);
        do_fetch(0, 32'h1000_0003, 32'h200);
        consume(1'b1, 16'h0003, 32'h210);
        do_fetch(0, 32'h2108_0001, 32'h210);
        consume(1'b1, 16'hFF7A, 32'hFFFF_FFFC);
    endtask

    task automatic test_wrap;
        do_fetch(0, 32'h0800_0040, 32'hFFFF_FFFC);
        consume(1'b0, 16'h0000, 32'h0);
    endtask

    task automatic test_reset_mid;
        step();
        step();
        Reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_req: req=%b expected 0", imem_req);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0 || Instruction !== 32'h0 || PC_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_regs: valid=%b ir=%h pc_out=%h expected 0 0 0", instr_valid, Instruction, PC_out);
        end
        step();
        Reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || Instruction !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_restart: req=%b addr=%h ir=%h expected 1 00000100 0", imem_req, imem_addr, Instruction);
        end
        lastIr = '0;
    endtask

    task automatic test_timeout;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait: req=%b err=%b expected 1 0", imem_req, fetch_err);
            end
            imem_ack = 1'b0;
            step();
        end
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b req=%b valid=%b expected 1 0 0", fetch_err, imem_req, instr_valid);
        end
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b req=%b valid=%b expected 1 0 0", fetch_err, imem_req, instr_valid);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        lastIr = '0;
        do_fetch(3, 32'h3C01_1234, 32'h100);
`else
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'b0;
            step();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: req=%b addr=%h err=%b expected 1 00000100 0", imem_req, imem_addr, fetch_err);
        end
        do_fetch(0, 32'h3C01_1234, 32'h100);
`endif
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_err: err=%b expected 0", fetch_err);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
